// File: rtl/cx_job_sequencer.sv
// Job sequencer for the C_X calculator: buffers operands in a small FIFO,
// issues them one at a time and returns each result or a watchdog error.
module cx_job_sequencer #(
    parameter int W      = 16,
    parameter int DEPTH  = 4,
    parameter int TO_CYC = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_err,
    output logic         calc_start,
    output logic [W-1:0] calc_x,
    input  logic         calc_ready,
    input  logic [W-1:0] calc_result,
    output logic         busy,
    output logic [7:0]   jobs_done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        OUTPUT
    } state_t;

    state_t        state;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic [7:0]    timer;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = (state == ISSUE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Outputs are registered alongside the state so they change with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            calc_start <= 1'b0;
            calc_x     <= '0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_err    <= 1'b0;
            timer      <= '0;
            jobs_done  <= '0;
        end else begin
            calc_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!empty && calc_ready) begin
                        state      <= ISSUE;
                        calc_start <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ISSUE: begin
                    calc_x <= mem[rptr];
                    timer  <= '0;
                    state  <= WAIT_ACK;
                end
                WAIT_ACK, WAIT_DONE: begin
                    timer <= timer + 8'd1;
                    if (state == WAIT_ACK && !calc_ready) begin
                        state <= WAIT_DONE;
                    end else if (state == WAIT_DONE && calc_ready) begin
                        out_data  <= calc_result;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= OUTPUT;
                    end else if (timer == TO_LAST) begin
                        out_data  <= '0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        jobs_done <= jobs_done + 8'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cx_job_sequencer.md
Name: cx_job_sequencer

Overview:
Upstream feeder for the C_X calculation datapath/controller pair. Accepts operand words over a valid/ready stream and buffers them in a small FIFO. Issues one start pulse per operand to the calculator, holds the operand on the calculator's input bus, waits for the calculator's ready handshake, and returns the captured result (or a timeout error) over a second valid/ready stream. Jobs are strictly serialized; there is never more than one job in flight.

Parameters:
W, 16, operand/result width
DEPTH, 4, input FIFO depth; must be a power of 2 and at least 2
TO_CYC, 255, watchdog limit in cycles per job (max 255)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  operand offered
in_ready  out  1  FIFO can accept; equals !full
in_data  in  W  operand
out_valid  out  1  result/error available
out_ready  in  1  consumer accepts result
out_data  out  W  captured calculator result (0 on error)
out_err  out  1  1 = watchdog timeout for this job
calc_start  out  1  one-cycle start pulse to calculator
calc_x  out  W  operand bus to calculator; stable for the whole job
calc_ready  in  1  calculator idle/done flag
calc_result  in  W  calculator result register
busy  out  1  1 in any state other than IDLE
jobs_done  out  8  count of results accepted downstream; wraps 255->0

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; FIFO is emptied; pointers and timer are cleared.
  - in_ready=1; out_valid, out_err, calc_start and busy=0; out_data, calc_x and jobs_done=0.
  - Reset mid-job abandons the job silently; the next start is issued only after the calculator shows calc_ready=1.
- FIFO:
  - Push on in_valid&in_ready.
  - in_ready depends only on occupancy. When full, no push occurs, even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave occupancy unchanged.
  - Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits.
  - Registered storage; a word pushed at edge k is visible at the head from cycle k+1.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, OUTPUT.
  - IDLE: if FIFO non-empty and calc_ready=1 -> ISSUE. Otherwise stay.
  - ISSUE (exactly 1 cycle): calc_start=1. At the edge ending ISSUE: calc_x<=head, FIFO pop, timer<=0. -> WAIT_ACK.
    - calc_x is registered, so it becomes valid the cycle after start. The calculator samples x no earlier than 2 cycles after start, so this is safe.
  - WAIT_ACK: calc_ready=0 -> WAIT_DONE.
  - WAIT_DONE: calc_ready=1 -> out_data<=calc_result, out_err<=0 -> OUTPUT.
  - Timeout in WAIT_ACK or WAIT_DONE:
    - Timer increments every cycle in these two states.
    - If timer==TO_CYC-1 at a clock edge and the exit condition is false: out_data<=0, out_err<=1 -> OUTPUT.
    - The exit condition has priority over timeout in the same cycle.
  - OUTPUT: out_valid=1; out_data and out_err are held stable. On out_ready -> IDLE and jobs_done+1.
- Latency:
  - Empty FIFO, calculator idle: push at edge k, calc_start high in cycle k+2.
  - Result appears on out_valid one cycle after calc_ready returns to 1.
- calc_start is never asserted twice without an intervening calc_ready low->high cycle or timeout.
- FIFO pushes continue in every state; back-pressure only via in_ready.
- No arithmetic on data; widths pass through unchanged.

Test Plan:
- Single job: push 0x0005; calculator model drops ready 1 cycle after start and raises it 10 cycles later with result 0x00A0 -> exactly one calc_start pulse; calc_x=0x0005 from the cycle after start until OUTPUT; out_data=0x00A0, out_err=0, jobs_done=1.
- Burst/back-pressure: push 6 words (1..6) with DEPTH=4 while the calculator is slow -> in_ready=0 whenever occupancy=4; results emerge in order 1..6; exactly 6 start pulses; jobs_done=6.
- Output stall: hold out_ready=0 for 20 cycles in OUTPUT -> out_valid and out_data stable; no new calc_start; FIFO still accepts up to DEPTH words.
- Timeout: calculator never drops ready (TO_CYC=8) -> out_err=1 and out_data=0 exactly 8 cycles after leaving ISSUE; the next job still processes normally.
- Reset mid-job: assert rst low during WAIT_DONE with 2 words queued -> all outputs at reset values immediately; FIFO empty; after release, no start is issued until a new push arrives.
- Wrap: run 258 jobs -> jobs_done=2; FIFO pointers wrap with correct data ordering throughout.
